// File: rtl/jt51_wr_sched_if.sv
// ---------------------------------------------------------------------------
// jt51_wr_sched_if
//   Bundles every non-clock/reset signal of the JT51 write scheduler.
//   master : the surroundings of the scheduler (host CPU port, playback engine,
//            flush control and the busy flag coming back from the register
//            interface).
//   slave  : the scheduler itself.
//   Signals:
//     cen                 synth clock enable (informational)
//     flush               drop all queued, not yet popped entries
//     h_valid/h_ready     host request handshake, h_addr/h_data payload
//     p_valid/p_ready     player request handshake, p_addr/p_data payload
//     mmr_write/a0/din    registered strobe, phase select and bus value
//     mmr_busy            busy flag from the register interface
//     level               FIFO occupancy (0 .. 2^AW)
//     idle                FIFO empty and sequencer idle
// ---------------------------------------------------------------------------
interface jt51_wr_sched_if #(
  parameter int AW = 4
);
  logic          cen;
  logic          flush;
  logic          h_valid;
  logic          h_ready;
  logic [7:0]    h_addr;
  logic [7:0]    h_data;
  logic          p_valid;
  logic          p_ready;
  logic [7:0]    p_addr;
  logic [7:0]    p_data;
  logic          mmr_write;
  logic          mmr_a0;
  logic [7:0]    mmr_din;
  logic          mmr_busy;
  logic [AW:0]   level;
  logic          idle;

  modport master (
    output cen, flush,
    output h_valid, h_addr, h_data,
    output p_valid, p_addr, p_data,
    output mmr_busy,
    input  h_ready, p_ready,
    input  mmr_write, mmr_a0, mmr_din,
    input  level, idle
  );

  modport slave (
    input  cen, flush,
    input  h_valid, h_addr, h_data,
    input  p_valid, p_addr, p_data,
    input  mmr_busy,
    output h_ready, p_ready,
    output mmr_write, mmr_a0, mmr_din,
    output level, idle
  );
endinterface

// File: rtl/jt51_wr_sched.sv
// ---------------------------------------------------------------------------
// jt51_wr_sched
//   Write scheduler in front of the JT51 register interface. Register writes
//   from the host CPU port and the playback engine are arbitrated round-robin
//   into a 2^AW x 16 FIFO ({addr, data}). Each entry is replayed as an
//   address write, a one-clock gap, a data write, a one-clock hold, then a
//   wait for the busy flag to drop. The address phase is skipped when the
//   target register is already selected on the chip.
//   Ports:
//     clk  system clock (same as the register interface)
//     rst  asynchronous active-high reset
//     bus  jt51_wr_sched_if.slave (handshakes, register bus, status)
// ---------------------------------------------------------------------------
module jt51_wr_sched #(
  parameter int AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  jt51_wr_sched_if.slave     bus
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_GAP,
    S_DATA,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic          rr_host_q;          // 1: host wins the next contested cycle
  logic [7:0]    a_q, d_q;           // entry being replayed
  logic [7:0]    cache_q;            // register currently selected on the chip
  logic          cache_vld_q;
  logic          write_q, a0_q;
  logic [7:0]    din_q;
  logic          write_d, a0_d;
  logic [7:0]    din_d;

  logic          full, empty;
  logic          h_grant, p_grant, push, pop;
  logic [15:0]   head, push_word;
  logic [7:0]    cur_a, cur_d;
  logic          unused_cen;

  assign unused_cen = bus.cen;

  // ---------------- arbitration ----------------
  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);

  // The grant goes to whoever was not served last; a lone requester is
  // served whenever there is room. Flush blocks pushes for its clock.
  assign h_grant = !full && !bus.flush && bus.h_valid && (!bus.p_valid ||  rr_host_q);
  assign p_grant = !full && !bus.flush && bus.p_valid && (!bus.h_valid || !rr_host_q);
  assign push      = h_grant || p_grant;
  assign push_word = h_grant ? {bus.h_addr, bus.h_data} : {bus.p_addr, bus.p_data};

  assign bus.h_ready = h_grant;
  assign bus.p_ready = p_grant;

  // Asynchronous head read: IDLE must know the address in the same clock it
  // pops so it can decide between the ADDR and DATA paths.
  assign head = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= push_word;
    end
  end

  // ---------------- sequencer ----------------
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    cur_a   = a_q;
    cur_d   = d_q;
    case (state_q)
      S_IDLE: begin
        // A flush in the same clock wins over the pop.
        if (!empty && !bus.flush) begin
          pop     = 1'b1;
          cur_a   = head[15:8];
          cur_d   = head[7:0];
          state_d = (cache_vld_q && cache_q == head[15:8]) ? S_DATA : S_ADDR;
        end
      end
      S_ADDR:  state_d = S_GAP;
      S_GAP:   state_d = S_DATA;
      S_DATA:  state_d = S_HOLD;
      S_HOLD:  state_d = S_WAIT;
      S_WAIT:  if (!bus.mmr_busy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered: they are computed from the state being entered
    // so the strobe lines up exactly with the ADDR/DATA clocks.
    write_d = (state_d == S_ADDR) || (state_d == S_DATA);
    a0_d    = a0_q;
    din_d   = din_q;
    if (state_d == S_ADDR) begin
      a0_d  = 1'b0;
      din_d = cur_a;
    end else if (state_d == S_DATA) begin
      a0_d  = 1'b1;
      din_d = cur_d;
    end
  end

  always_comb begin
    if (bus.flush) begin
      level_d = '0;
    end else begin
      level_d = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rr_host_q   <= 1'b1;
      a_q         <= '0;
      d_q         <= '0;
      cache_q     <= '0;
      cache_vld_q <= 1'b0;
      write_q     <= 1'b0;
      a0_q        <= 1'b0;
      din_q       <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      write_q <= write_d;
      a0_q    <= a0_d;
      din_q   <= din_d;

      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end

      if (bus.flush) begin
        rd_ptr_q <= wr_ptr_q;
      end else if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end

      if (h_grant) begin
        rr_host_q <= 1'b0;
      end else if (p_grant) begin
        rr_host_q <= 1'b1;
      end

      if (pop) begin
        a_q <= cur_a;
        d_q <= cur_d;
      end

      // The chip's address latch is loaded by the ADDR write.
      if (state_q == S_ADDR) begin
        cache_q     <= a_q;
        cache_vld_q <= 1'b1;
      end
    end
  end

  assign bus.mmr_write = write_q;
  assign bus.mmr_a0    = a0_q;
  assign bus.mmr_din   = din_q;
  assign bus.level     = level_q;
  assign bus.idle      = empty && (state_q == S_IDLE);

endmodule

// File: tb/tb_jt51_wr_sched.sv
// ---------------------------------------------------------------------------
// tb_jt51_wr_sched
//   Randomized and directed stimulus for jt51_wr_sched. A transaction-level
//   model keeps the queued entries, the selected register and, per popped
//   entry, the clocks at which bus writes must appear and how long the chip
//   stays busy. Every bus write is printed on one line.
// ---------------------------------------------------------------------------
module tb_jt51_wr_sched;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jt51_wr_sched_if #(.AW(AW)) bus ();

  jt51_wr_sched #(.AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         c;
    logic       a0;
    logic [7:0] din;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] mq[$];        // queued entries, oldest first
  wr_t         wq[$];        // expected bus writes, in time order
  logic        host_turn;
  logic        cache_vld;
  logic [7:0]  cache_val;
  int          next_free;    // first clock the sequencer can pop again
  int          busy_lo, busy_hi;
  int          force_b = -1; // >=0 forces the busy length of the next pops
  logic        acc_h, acc_p;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    wq.delete();
    host_turn = 1'b1;
    cache_vld = 1'b0;
    cache_val = 8'h00;
    next_free = cyc;
    busy_lo   = 1;
    busy_hi   = 0;
  endtask

  task automatic expect_wr(input int c, input logic a0, input logic [7:0] d);
    wr_t w;
    w.c = c; w.a0 = a0; w.din = d;
    wq.push_back(w);
  endtask

  // One clock: drive inputs, check outputs at mid-cycle, advance the model.
  task automatic cycle(input logic hv, input logic [7:0] ha, input logic [7:0] hd,
                       input logic pv, input logic [7:0] pa, input logic [7:0] pd,
                       input logic fl);
    logic        full, eh, ep, ew, pop;
    logic [15:0] e;
    int          b, dc;
    #1;
    bus.h_valid  = hv; bus.h_addr = ha; bus.h_data = hd;
    bus.p_valid  = pv; bus.p_addr = pa; bus.p_data = pd;
    bus.flush    = fl;
    bus.mmr_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
    #4;
    full = (mq.size() == DEPTH);
    eh = !full && !fl && hv && (!pv || host_turn);
    ep = !full && !fl && pv && (!hv || !host_turn);
    check_eq("h_ready", bus.h_ready, eh);
    check_eq("p_ready", bus.p_ready, ep);
    check_eq("level", bus.level, mq.size());
    check_eq("idle", bus.idle, (mq.size() == 0) && (cyc >= next_free));
    ew = (wq.size() > 0) && (wq[0].c == cyc);
    check_eq("mmr_write", bus.mmr_write, ew);
    if (ew) begin
      check_eq("mmr_a0", bus.mmr_a0, wq[0].a0);
      check_eq("mmr_din", bus.mmr_din, wq[0].din);
      $display("WR cyc=%0d a0=%0d din=%02h level=%0d", cyc, bus.mmr_a0, bus.mmr_din, bus.level);
      void'(wq.pop_front());
    end

    pop = !fl && (cyc >= next_free) && (mq.size() > 0);
    if (pop) begin
      e = mq.pop_front();
      b = (force_b >= 0) ? force_b : int'($urandom_range(0, 4));
      if (cache_vld && cache_val == e[15:8]) begin
        expect_wr(cyc + 1, 1'b1, e[7:0]);
        dc = cyc + 1;
      end else begin
        expect_wr(cyc + 1, 1'b0, e[15:8]);
        expect_wr(cyc + 3, 1'b1, e[7:0]);
        dc = cyc + 3;
        cache_vld = 1'b1;
        cache_val = e[15:8];
      end
      busy_lo   = dc + 1;
      busy_hi   = dc + b;
      next_free = dc + 2 + ((b > 1) ? b : 1);
    end
    if (eh) begin
      mq.push_back({ha, hd});
      host_turn = 1'b0;
    end else if (ep) begin
      mq.push_back({pa, pd});
      host_turn = 1'b1;
    end
    if (fl) mq.delete();
    acc_h = eh;
    acc_p = ep;
    @(posedge clk);
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while ((mq.size() > 0 || wq.size() > 0 || cyc < next_free) && n < 1000) begin
      cycle(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      n++;
    end
    check_eq("drain_timeout", n >= 1000, 0);
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  function automatic logic [7:0] pick_addr(input int k);
    case (k)
      0:       return 8'h08;
      1:       return 8'h20;
      2:       return 8'h28;
      default: return 8'h30;
    endcase
  endfunction

  initial begin
    int hi, pi, n;
    rst = 1'b1;
    bus.cen = 1'b1; bus.flush = 1'b0; bus.mmr_busy = 1'b0;
    bus.h_valid = 1'b0; bus.h_addr = 8'h00; bus.h_data = 8'h00;
    bus.p_valid = 1'b0; bus.p_addr = 8'h00; bus.p_data = 8'h00;
    repeat (2) @(posedge clk);
    #2;
    check_eq("reset_level", bus.level, 0);
    check_eq("reset_idle", bus.idle, 1);
    check_eq("reset_write", bus.mmr_write, 0);
    check_eq("reset_din", bus.mmr_din, 0);
    rst = 1'b0;
    @(posedge clk);
    model_reset();

    // Single write, full address + data sequence.
    cycle(1'b1, 8'h20, 8'hC7, 1'b0, 8'h00, 8'h00, 1'b0);
    drain();

    // Repeated register: second entry has no address phase.
    cycle(1'b1, 8'h28, 8'h4A, 1'b0, 8'h00, 8'h00, 1'b0);
    cycle(1'b1, 8'h28, 8'h4C, 1'b0, 8'h00, 8'h00, 1'b0);
    drain();

    // Both requesters streaming: grants alternate.
    hi = 0; pi = 0; n = 0;
    while ((hi < 2 || pi < 2) && n < 20) begin
      cycle(hi < 2, 8'h08, 8'(hi + 1), pi < 2, 8'h30, 8'(8'h10 + pi), 1'b0);
      if (acc_h) hi++;
      if (acc_p) pi++;
      n++;
    end
    check_eq("stream_done", (hi == 2) && (pi == 2), 1);
    drain();

    // Fill the FIFO behind a long busy window, then keep pushing.
    force_b = 60;
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'h40, 8'(i), 1'b0, 8'h00, 8'h00, 1'b0);
    force_b = -1;
    #1;
    check_eq("fill_level", bus.level, DEPTH);
    check_eq("fill_h_ready", bus.h_ready, 0);
    for (int i = 0; i < 70; i++) cycle(1'b1, 8'h48, 8'(i), 1'b0, 8'h00, 8'h00, 1'b0);
    drain();

    // Flush while the sequencer waits on busy with entries queued.
    force_b = 30;
    for (int i = 0; i < 6; i++) cycle(1'b1, pick_addr(i % 4), 8'(8'h90 + i), 1'b0, 8'h00, 8'h00, 1'b0);
    force_b = -1;
    repeat (3) cycle(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    check_eq("flush_pre_level", mq.size() == 5, 1);
    cycle(1'b1, 8'h55, 8'h55, 1'b0, 8'h00, 8'h00, 1'b1);
    #1;
    check_eq("flush_level", bus.level, 0);
    drain();

    // Reset during a data write.
    cycle(1'b1, 8'h20, 8'h11, 1'b0, 8'h00, 8'h00, 1'b0);
    cycle(1'b1, 8'h20, 8'h22, 1'b0, 8'h00, 8'h00, 1'b0);
    cycle(1'b1, 8'h20, 8'h33, 1'b0, 8'h00, 8'h00, 1'b0);
    n = 0;
    while (!(wq.size() > 0 && wq[0].a0 && wq[0].c == cyc) && n < 100) begin
      cycle(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      n++;
    end
    check_eq("reach_data_timeout", n >= 100, 0);
    #1;
    check_eq("pre_rst_write", bus.mmr_write, 1);
    bus.h_valid = 1'b0; bus.p_valid = 1'b0; bus.flush = 1'b0; bus.mmr_busy = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("rst_write", bus.mmr_write, 0);
    check_eq("rst_level", bus.level, 0);
    check_eq("rst_a0", bus.mmr_a0, 0);
    check_eq("rst_idle", bus.idle, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    cyc += 2;
    model_reset();
    cycle(1'b1, 8'h20, 8'h5A, 1'b0, 8'h00, 8'h00, 1'b0);
    drain();

    // Randomized traffic from both requesters with occasional flushes.
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 1) == 1, pick_addr($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
            $urandom_range(0, 1) == 1, pick_addr($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
            $urandom_range(0, 49) == 0);
    end
    drain();
    #1;
    check_eq("final_idle", bus.idle, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
